mem_port_arbiter: RTL and testbench

//  Arbitrates the single unified memory between instruction fetch (I port, read-only) and the

---
 rtl/mips_mem_pkg.sv | 15 +
 rtl/mem_port_arbiter_if.sv | 37 +++
 rtl/mem_port_arbiter_pick.sv | 20 ++
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared types and constants for the unified memory port arbiter
package mips_mem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and memory-side signals of the arbiter
interface mem_port_arbiter_if;
    import mips_mem_pkg::*;

    logic              i_req;
    logic [WORD_W-1:0] i_addr;
    logic [WORD_W-1:0] i_rdata;
    logic              i_ack;

    logic              d_req;
    logic              d_write;
    logic [WORD_W-1:0] d_addr;
    logic [WORD_W-1:0] d_wdata;
    logic [WORD_W-1:0] d_rdata;
    logic              d_ack;

    logic [WORD_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_write;
    logic [WORD_W-1:0] mem_rdata;

    logic              busy;
    logic              owner;

    // Arbiter side
    modport slave (
        input  i_req, i_addr, d_req, d_write, d_addr, d_wdata, mem_rdata,
        output i_rdata, i_ack, d_rdata, d_ack, mem_addr, mem_wdata, mem_write, busy, owner
    );

    // Requesters plus memory side
    modport master (
        output i_req, i_addr, d_req, d_write, d_addr, d_wdata, mem_rdata,
        input  i_rdata, i_ack, d_rdata, d_ack, mem_addr, mem_wdata, mem_write, busy, owner
    );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// rtl/mem_port_arbiter_pick.sv - combinational owner pick, data first with fetch starvation guard
module mem_arb_pick
    import mips_mem_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic streak_full,
    output logic grant_valid,
    output logic grant_owner
);

    always_comb begin
        grant_valid = i_req | d_req;
        grant_owner = OWNER_I;
        if (d_req && !(i_req && streak_full)) begin
            grant_owner = OWNER_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - sequences I/D accesses to the unified memory over LATENCY cycles
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int LATENCY      = 2,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    mem_port_arbiter_if.slave       bus
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int STK_W = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [STK_W-1:0]   streak;
    logic [WORD_W-1:0]  lat_addr;
    logic [WORD_W-1:0]  lat_wdata;
    logic               lat_write;
    logic               owner_q;
    logic [WORD_W-1:0]  i_rdata_q;
    logic [WORD_W-1:0]  d_rdata_q;

    logic               streak_full;
    logic               grant_valid;
    logic               grant_owner;
    logic               mem_write;
    logic               i_ack;
    logic               d_ack;
    logic               busy;

    assign streak_full = (streak == STK_W'(MAX_D_STREAK));

    mem_arb_pick u_pick (
        .i_req       (bus.i_req),
        .d_req       (bus.d_req),
        .streak_full (streak_full),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    always_comb begin
        state_next = state;
        mem_write  = 1'b0;
        i_ack      = 1'b0;
        d_ack      = 1'b0;
        busy       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                busy = 1'b1;
                // Write strobe only on the closing cycle: one commit edge per store
                if (cnt == '0) begin
                    mem_write  = lat_write;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                busy       = 1'b1;
                i_ack      = (owner_q == OWNER_I);
                d_ack      = (owner_q == OWNER_D);
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            streak    <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_write <= 1'b0;
            owner_q   <= OWNER_I;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        owner_q   <= grant_owner;
                        cnt       <= CNT_W'(LATENCY - 1);
                        lat_addr  <= (grant_owner == OWNER_D) ? bus.d_addr : bus.i_addr;
                        lat_wdata <= (grant_owner == OWNER_D) ? bus.d_wdata : '0;
                        lat_write <= (grant_owner == OWNER_D) && bus.d_write;
                        // Streak counts D wins only while fetch is actually waiting
                        if (grant_owner == OWNER_D && bus.i_req) begin
                            if (!streak_full) begin
                                streak <= streak + STK_W'(1);
                            end
                        end else begin
                            streak <= '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (owner_q == OWNER_D) begin
                        d_rdata_q <= bus.mem_rdata;
                    end else begin
                        i_rdata_q <= bus.mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_addr  = lat_addr;
    assign bus.mem_wdata = lat_wdata;
    assign bus.mem_write = mem_write;
    assign bus.i_ack     = i_ack;
    assign bus.d_ack     = d_ack;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.busy      = busy;
    assign bus.owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
    import mips_mem_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic reset2 = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if a ();
    mem_port_arbiter_if b ();

    mem_port_arbiter #(.LATENCY(2), .MAX_D_STREAK(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (a.slave)
    );

    mem_port_arbiter #(.LATENCY(3), .MAX_D_STREAK(4)) dut2 (
        .clk   (clk),
        .reset (reset2),
        .bus   (b.slave)
    );

    logic [7:0] mem1 [256];
    logic [7:0] mem2 [256] = '{default: 8'h00};

    assign a.mem_rdata = {mem1[a.mem_addr[7:0] + 8'd3], mem1[a.mem_addr[7:0] + 8'd2],
                          mem1[a.mem_addr[7:0] + 8'd1], mem1[a.mem_addr[7:0]]};
    assign b.mem_rdata = {mem2[b.mem_addr[7:0] + 8'd3], mem2[b.mem_addr[7:0] + 8'd2],
                          mem2[b.mem_addr[7:0] + 8'd1], mem2[b.mem_addr[7:0]]};

    // Little-endian preload while the first instance is in its initial reset
    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 256; k++) mem1[k] <= 8'h00;
            mem1[8'h00] <= 8'h10; mem1[8'h01] <= 8'h00; mem1[8'h02] <= 8'h00; mem1[8'h03] <= 8'h0C;
            mem1[8'h10] <= 8'h04; mem1[8'h11] <= 8'h00; mem1[8'h12] <= 8'h22; mem1[8'h13] <= 8'h8C;
            mem1[8'h30] <= 8'h44; mem1[8'h31] <= 8'h33; mem1[8'h32] <= 8'h22; mem1[8'h33] <= 8'h11;
        end else if (a.mem_write) begin
            mem1[a.mem_addr[7:0]]         <= a.mem_wdata[7:0];
            mem1[a.mem_addr[7:0] + 8'd1]  <= a.mem_wdata[15:8];
            mem1[a.mem_addr[7:0] + 8'd2]  <= a.mem_wdata[23:16];
            mem1[a.mem_addr[7:0] + 8'd3]  <= a.mem_wdata[31:24];
        end
    end

    always @(posedge clk) begin
        if (b.mem_write) begin
            mem2[b.mem_addr[7:0]]         <= b.mem_wdata[7:0];
            mem2[b.mem_addr[7:0] + 8'd1]  <= b.mem_wdata[15:8];
            mem2[b.mem_addr[7:0] + 8'd2]  <= b.mem_wdata[23:16];
            mem2[b.mem_addr[7:0] + 8'd3]  <= b.mem_wdata[31:24];
        end
    end

    typedef struct packed {
        logic        owner;
        logic        chk_data;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   mw1 = 0;
    int   mw2 = 0;
    int   acks2 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic wait_ack(input string tag, output int edges);
        edges = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #2;
            if (a.i_ack || a.d_ack) begin
                edges = k;
                break;
            end
        end
        n_vec++;
        assert (edges >= 0) else begin
            n_err++;
            $error("FAIL %s: observed no ack within 30 cycles, expected an ack", tag);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (a.mem_write) mw1++;
        if (b.mem_write) mw2++;
        if (b.i_ack || b.d_ack) acks2++;
        if (!reset && (a.i_ack || a.d_ack)) begin
            chk("single_ack", {31'd0, a.i_ack & a.d_ack}, 32'd0);
            n_vec++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL sb_empty: observed ack owner %0d, expected no ack", a.owner);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("ack_owner", {31'd0, a.owner}, {31'd0, e.owner});
                chk("ack_port", {31'd0, e.owner ? a.d_ack : a.i_ack}, 32'd1);
                if (e.chk_data) chk("ack_rdata", e.owner ? a.d_rdata : a.i_rdata, e.data);
            end
        end
    end

    initial begin
        int e1;
        int e2;
        int c1;
        int base;
        int base2;
        exp_t ent;

        a.i_req = 1'b1; a.i_addr = 32'h10;
        a.d_req = 1'b1; a.d_write = 1'b0; a.d_addr = 32'h30; a.d_wdata = 32'h0;
        b.i_req = 1'b0; b.i_addr = 32'h0;
        b.d_req = 1'b0; b.d_write = 1'b0; b.d_addr = 32'h0; b.d_wdata = 32'h0;

        // Reset held three cycles with both requests up
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_i_ack", {31'd0, a.i_ack}, 32'd0);
            chk("rst_d_ack", {31'd0, a.d_ack}, 32'd0);
            chk("rst_mem_write", {31'd0, a.mem_write}, 32'd0);
            chk("rst_busy", {31'd0, a.busy}, 32'd0);
        end
        chk("rst_owner", {31'd0, a.owner}, 32'd0);
        chk("rst_mem_addr", a.mem_addr, 32'd0);
        chk("rst_mem_wdata", a.mem_wdata, 32'd0);
        chk("rst_i_rdata", a.i_rdata, 32'd0);
        chk("rst_d_rdata", a.d_rdata, 32'd0);
        ent = '{owner: OWNER_D, chk_data: 1'b1, data: 32'h11223344};
        exp_q.push_back(ent);
        @(posedge clk); #1;
        reset = 1'b0; reset2 = 1'b0;
        wait_ack("rst_first_ack", e1);
        chk("rst_first_ack_edge", e1, 32'd3);
        chk("rst_first_is_d", {31'd0, a.d_ack}, 32'd1);
        a.i_req = 1'b0; a.d_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single fetch
        base = mw1;
        ent = '{owner: OWNER_I, chk_data: 1'b1, data: 32'h8C220004};
        exp_q.push_back(ent);
        a.i_addr = 32'h10; a.i_req = 1'b1;
        wait_ack("fetch_ack", e1);
        chk("fetch_latency", e1, 32'd3);
        chk("fetch_is_i", {31'd0, a.i_ack}, 32'd1);
        chk("fetch_d_rdata_held", a.d_rdata, 32'h11223344);
        a.i_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("fetch_no_write", mw1 - base, 32'd0);

        // Same-cycle fetch and store: D first, then I
        base = mw1;
        ent = '{owner: OWNER_D, chk_data: 1'b0, data: 32'h0};
        exp_q.push_back(ent);
        ent = '{owner: OWNER_I, chk_data: 1'b1, data: 32'h0C000010};
        exp_q.push_back(ent);
        a.i_addr = 32'h0; a.d_addr = 32'h20; a.d_wdata = 32'hDEADBEEF; a.d_write = 1'b1;
        a.i_req = 1'b1; a.d_req = 1'b1;
        wait_ack("both_first", e1);
        chk("both_first_is_d", {31'd0, a.d_ack}, 32'd1);
        c1 = cyc;
        a.d_req = 1'b0; a.d_write = 1'b0;
        wait_ack("both_second", e2);
        chk("both_second_is_i", {31'd0, a.i_ack}, 32'd1);
        chk("both_ack_spacing", cyc - c1, 32'd4);
        a.i_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("store_one_write", mw1 - base, 32'd1);
        chk("store_byte0", {24'd0, mem1[8'h20]}, 32'hEF);
        chk("store_word", {mem1[8'h23], mem1[8'h22], mem1[8'h21], mem1[8'h20]}, 32'hDEADBEEF);

        // Idle stretch
        base = mw1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("idle_busy", {31'd0, a.busy}, 32'd0);
            chk("idle_acks", {30'd0, a.i_ack, a.d_ack}, 32'd0);
        end
        chk("idle_no_write", mw1 - base, 32'd0);
        chk("idle_streak", 32'(dut.streak), 32'd0);
        @(posedge clk); #1;

        // Both requests held: D,D,D,D,I repeating
        a.d_addr = 32'h30; a.d_write = 1'b0; a.i_addr = 32'h10;
        for (int n = 0; n < 15; n++) begin
            if (n % 5 == 4) ent = '{owner: OWNER_I, chk_data: 1'b1, data: 32'h8C220004};
            else            ent = '{owner: OWNER_D, chk_data: 1'b1, data: 32'h11223344};
            exp_q.push_back(ent);
        end
        a.i_req = 1'b1; a.d_req = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            #2;
            if (exp_q.size() == 0) break;
        end
        a.i_req = 1'b0; a.d_req = 1'b0;
        chk("stream_drained", exp_q.size(), 32'd0);
        repeat (3) @(posedge clk);
        #1;

        // LATENCY=3 store aborted by reset in its first ACCESS cycle
        base2 = mw2;
        c1 = acks2;
        b.d_addr = 32'h40; b.d_wdata = 32'hCAFEF00D; b.d_write = 1'b1; b.d_req = 1'b1;
        @(posedge clk); #1;
        chk("abort_in_access", {31'd0, b.busy}, 32'd1);
        reset2 = 1'b1; b.d_req = 1'b0; b.d_write = 1'b0;
        @(posedge clk); #1;
        reset2 = 1'b0;
        chk("abort_idle_busy", {31'd0, b.busy}, 32'd0);
        repeat (8) @(posedge clk);
        #1;
        chk("abort_no_write", mw2 - base2, 32'd0);
        chk("abort_no_ack", acks2 - c1, 32'd0);
        chk("abort_mem", {mem2[8'h43], mem2[8'h42], mem2[8'h41], mem2[8'h40]}, 32'h0);
        chk("abort_state", 32'(dut2.state), 32'(ST_IDLE));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed run still active, expected completion");
        $fatal(1, "timeout");
    end

endmodule
